ram_io_responder: RTL and testbench

- Byte-wide memory-bus responder: the far end of the CPU's mem_a / mem_dout / mem_wr / mem_din interface.
- Holds 128KB of RAM and decodes the memory-mapped I/O window (mem_a[17:16]==2'b11).
- The I/O window provides a UART-style input byte FIFO, an output byte FIFO, a free-running cycle counter and a program-stop flag.
- Gives the CPU the contracted timing: read data one cycle after the address is presented, writes committed in the presenting cycle.

---
 rtl/ram_io_responder.sv | 143 ++++++++++++++
 tb/tb_ram_io_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_io_responder.sv
// Byte-wide memory-bus responder: 128KB RAM plus an I/O window with rx/tx byte FIFOs,
// a free-running cycle counter with a coherent snapshot, and a sticky program-stop flag.
module ram_io_responder #(
    parameter int RAM_AW          = 17,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_done,
    output logic        tx_overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;

    logic [7:0]  ram_q    [0:(1<<RAM_AW)-1];
    logic [7:0]  rx_mem_q [0:DEPTH-1];
    logic [7:0]  tx_mem_q [0:DEPTH-1];
    ptr_t        rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
    cnt_t        rx_cnt_q, tx_cnt_q;
    logic [31:0] cyc_q, snap_q;
    logic [7:0]  din_q, din_d;
    logic        done_q, ovf_q;

    logic        sel_ram, sel_io, bus_rd, bus_wr;
    logic [2:0]  io_off;
    logic        rx_empty, rx_push, rx_pop;
    logic        tx_full, tx_req, tx_push, tx_pop;
    logic [7:0]  tx_byte;
    logic        snap_load, done_set, ram_we;
    logic        unused_addr;

    assign unused_addr = ^mem_a[31:18];

    assign sel_ram = ~mem_a[17];
    assign sel_io  = mem_a[17] & mem_a[16];
    assign io_off  = mem_a[2:0];
    assign bus_rd  = rdy_in & ~mem_wr;
    assign bus_wr  = rdy_in & mem_wr;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_ready = (rx_cnt_q != CNT_FULL);
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = bus_rd & sel_io & (io_off == 3'd0) & ~rx_empty;

    // A zero byte written to the data port is treated as "nothing to send".
    assign tx_req   = bus_wr & sel_io &
                      (((io_off == 3'd0) & (mem_dout != 8'h00)) | (io_off == 3'd4));
    assign tx_byte  = (io_off == 3'd4) ? 8'h00 : mem_dout;
    assign tx_full  = (tx_cnt_q == CNT_FULL);
    assign tx_push  = tx_req & ~tx_full;
    assign tx_valid = (tx_cnt_q != '0);
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_data  = tx_mem_q[tx_rp_q];

    assign snap_load = bus_rd & sel_io & (io_off == 3'd4);
    assign done_set  = bus_wr & sel_io & (io_off == 3'd4);
    assign ram_we    = bus_wr & sel_ram & ~rst_in;

    assign mem_din     = din_q;
    assign prog_done   = done_q;
    assign tx_overflow = ovf_q;

    always_comb begin
        din_d = din_q;
        if (bus_rd) begin
            din_d = 8'h00;
            if (sel_ram) begin
                din_d = ram_q[mem_a[RAM_AW-1:0]];
            end else if (sel_io) begin
                case (io_off)
                    3'd0: if (!rx_empty) din_d = rx_mem_q[rx_rp_q];
                    // Offset 4 returns the live count; 5..7 come from the snapshot
                    // taken on that same read so a multi-byte read stays coherent.
                    3'd4: din_d = cyc_q[7:0];
                    3'd5: din_d = snap_q[15:8];
                    3'd6: din_d = snap_q[23:16];
                    3'd7: din_d = snap_q[31:24];
                    default: din_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            din_q    <= 8'h00;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cyc_q    <= 32'd0;
            snap_q   <= 32'd0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            din_q <= din_d;
            cyc_q <= cyc_q + 32'd1;
            if (snap_load)        snap_q <= cyc_q;
            if (done_set)         done_q <= 1'b1;
            if (tx_req & tx_full) ovf_q  <= 1'b1;

            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
                default: rx_cnt_q <= rx_cnt_q;
            endcase

            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // Storage arrays carry no reset; RAM contents survive rst_in.
    always_ff @(posedge clk_in) begin
        if (ram_we)              ram_q[mem_a[RAM_AW-1:0]] <= mem_dout;
        if (rx_push & ~rst_in)   rx_mem_q[rx_wp_q]        <= rx_data;
        if (tx_push & ~rst_in)   tx_mem_q[tx_wp_q]        <= tx_byte;
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: queue/array reference model checked every cycle,
// plus hand-computed literal checks at the scenario boundaries.
module tb_ram_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, mem_wr, rx_valid, tx_ready;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, rx_data;
    logic [7:0]  mem_din, tx_data;
    logic        rx_ready, tx_valid, prog_done, tx_overflow;

    int vectors = 0;
    int errors  = 0;

    always #5 clk_in = ~clk_in;

    ram_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .prog_done(prog_done), .tx_overflow(tx_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [7:0]  ram_m [int];
    logic [7:0]  rxq [$];
    logic [7:0]  txq [$];
    logic [31:0] cnt_m, snap_m;
    logic [7:0]  din_m, txb_m;
    bit          din_known, pd_m, ovf_m, model_live = 0, tx_req_m;
    int          rx_n, tx_n;
    logic [17:0] a_m;

    always @(posedge clk_in) begin
        if (rst_in) begin
            rxq.delete(); txq.delete();
            cnt_m = 0; snap_m = 0; din_m = 0; din_known = 1;
            pd_m = 0; ovf_m = 0; model_live = 1;
        end else if (model_live) begin
            rx_n = rxq.size();
            tx_n = txq.size();
            a_m  = mem_a[17:0];
            tx_req_m = 0;
            if (rdy_in && !mem_wr) begin
                din_known = 1;
                if (!a_m[17]) begin
                    if (ram_m.exists(int'(a_m[16:0]))) din_m = ram_m[int'(a_m[16:0])];
                    else din_known = 0;
                end else if (!a_m[16]) begin
                    din_m = 8'h00;
                end else begin
                    case (a_m[2:0])
                        3'd0: din_m = (rx_n > 0) ? rxq.pop_front() : 8'h00;
                        3'd4: begin din_m = cnt_m[7:0]; snap_m = cnt_m; end
                        3'd5, 3'd6, 3'd7: din_m = 8'(snap_m >> (8 * a_m[1:0]));
                        default: din_m = 8'h00;
                    endcase
                end
            end
            if (rdy_in && mem_wr) begin
                if (!a_m[17]) ram_m[int'(a_m[16:0])] = mem_dout;
                else if (a_m[16]) begin
                    if (a_m[2:0] == 3'd0 && mem_dout != 8'h00) begin
                        tx_req_m = 1; txb_m = mem_dout;
                    end else if (a_m[2:0] == 3'd4) begin
                        tx_req_m = 1; txb_m = 8'h00; pd_m = 1;
                    end
                end
            end
            if (rx_valid && rx_n < 8) rxq.push_back(rx_data);
            if (tx_ready && tx_n > 0) void'(txq.pop_front());
            if (tx_req_m) begin
                if (tx_n < 8) txq.push_back(txb_m);
                else ovf_m = 1;
            end
            cnt_m = cnt_m + 1;
        end
    end

    always @(negedge clk_in) begin
        if (model_live) begin
            chk("rx_ready", rx_ready, rxq.size() < 8);
            chk("tx_valid", tx_valid, txq.size() > 0);
            if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
            if (din_known) chk("mem_din", mem_din, din_m);
            chk("prog_done", prog_done, pd_m);
            chk("tx_overflow", tx_overflow, ovf_m);
        end
    end

    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic idle();
        rdy_in = 1; mem_wr = 0; mem_a = 32'h0002_0000; mem_dout = 8'h00;
    endtask

    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d, input logic rdy);
        rdy_in = rdy; mem_a = a; mem_wr = wr; mem_dout = d;
        cyc();
        idle();
    endtask

    task automatic do_reset();
        rst_in = 1;
        repeat (2) cyc();
        rst_in = 0;
    endtask

    logic [31:0] word;

    initial begin
        idle();
        rx_valid = 0; rx_data = 0; tx_ready = 0;
        @(negedge clk_in);
        do_reset();
        chk("reset mem_din", mem_din, 8'h00);
        chk("reset rx_ready", rx_ready, 1);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset prog_done", prog_done, 0);
        chk("reset tx_overflow", tx_overflow, 0);

        // RAM write then read: data appears one edge after the read address
        bus(32'h0000_0010, 1, 8'hA5, 1);
        chk("ram pre-read din", mem_din, 8'h00);
        bus(32'h0000_0010, 0, 8'h00, 1);
        chk("ram read A5", mem_din, 8'hA5);

        // rx: two bytes in, three reads
        rx_valid = 1; rx_data = 8'h11; cyc();
        rx_data = 8'h22; cyc();
        rx_valid = 0;
        bus(32'h0003_0000, 0, 0, 1); chk("rx rd1", mem_din, 8'h11);
        bus(32'h0003_0000, 0, 0, 1); chk("rx rd2", mem_din, 8'h22);
        bus(32'h0003_0000, 0, 0, 1); chk("rx rd3 empty", mem_din, 8'h00);
        chk("rx_ready after", rx_ready, 1);

        // Empty rx: pop and push in the same cycle -> pop sees empty, push lands
        rx_valid = 1; rx_data = 8'h33;
        bus(32'h0003_0000, 0, 0, 1);
        rx_valid = 0;
        chk("rx simul empty", mem_din, 8'h00);
        bus(32'h0003_0000, 0, 0, 1); chk("rx simul landed", mem_din, 8'h33);

        // tx: 0x00 is skipped
        bus(32'h0003_0000, 1, 8'h48, 1);
        bus(32'h0003_0000, 1, 8'h00, 1);
        bus(32'h0003_0000, 1, 8'h69, 1);
        chk("tx head 48", tx_data, 8'h48);
        tx_ready = 1; cyc();
        chk("tx head 69", tx_data, 8'h69);
        cyc();
        chk("tx drained", tx_valid, 0);
        cyc();

        // tx overflow on the 9th byte
        tx_ready = 0;
        for (int i = 1; i <= 9; i++) bus(32'h0003_0000, 1, 8'(i), 1);
        chk("tx overflow", tx_overflow, 1);
        chk("tx full head", tx_data, 8'h01);
        tx_ready = 1;
        repeat (10) cyc();
        chk("tx overflow sticky", tx_overflow, 1);
        tx_ready = 0;

        // Counter snapshot: read at the edge where the counter is 1000
        do_reset();
        chk("ovf cleared by reset", tx_overflow, 0);
        repeat (1000) cyc();
        bus(32'h0003_0004, 0, 0, 1); word[7:0]   = mem_din;
        bus(32'h0003_0005, 0, 0, 1); word[15:8]  = mem_din;
        bus(32'h0003_0006, 0, 0, 1); word[23:16] = mem_din;
        bus(32'h0003_0007, 0, 0, 1); word[31:24] = mem_din;
        chk("counter snapshot", word, 32'h0000_03E8);

        // Hole and unused IO offset
        bus(32'h0002_0005, 1, 8'hEE, 1);
        bus(32'h0003_0002, 0, 0, 1); chk("io offset 2", mem_din, 8'h00);

        // rx full boundary and pointer wrap
        rx_valid = 1;
        for (int i = 0; i < 9; i++) begin rx_data = 8'h80 + 8'(i); cyc(); end
        rx_valid = 0;
        chk("rx full", rx_ready, 0);
        bus(32'h0003_0000, 0, 0, 1); chk("rx full head", mem_din, 8'h80);
        chk("rx not full", rx_ready, 1);
        for (int i = 0; i < 7; i++) bus(32'h0003_0000, 0, 0, 1);
        chk("rx last", mem_din, 8'h87);

        // rdy_in low freezes the bus side
        bus(32'h0000_0020, 1, 8'h5A, 1);
        rx_valid = 1; rx_data = 8'h77; cyc(); rx_valid = 0;
        bus(32'h0000_0020, 0, 0, 1);  chk("ram 20", mem_din, 8'h5A);
        bus(32'h0000_0020, 1, 8'hFF, 0); chk("frozen wr din", mem_din, 8'h5A);
        bus(32'h0003_0000, 0, 0, 0);  chk("frozen rd din", mem_din, 8'h5A);
        bus(32'h0000_0020, 0, 0, 1);  chk("ram 20 unchanged", mem_din, 8'h5A);
        bus(32'h0003_0000, 0, 0, 1);  chk("rx not popped", mem_din, 8'h77);
        bus(32'h0003_0004, 1, 8'h00, 1);
        chk("prog_done", prog_done, 1);
        chk("stop byte valid", tx_valid, 1);
        chk("stop byte", tx_data, 8'h00);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
